fit_smoother: RTL and testbench
===============================

FIT_SMOOTHER -- requirements
Module: fit_smoother

Interface
REQ-001 SHALL have parameter ALPHA_SHIFT, default 2, EMA weight 2^-ALPHA_SHIFT.
REQ-002 SHALL have parameter MAX_JUMP_A, default 64, max accepted |a_in - a_smooth|.
REQ-003 SHALL have parameter MAX_JUMP_B, default 256, max accepted |b_in - b_smooth|.
REQ-004 SHALL have parameter REJECT_LIMIT, default 3, consecutive rejects forcing reseed.
REQ-005 SHALL have parameter STALE_FRAMES, default 30, fit-less frames before stale.
REQ-006 SHALL have port clk_in, input, 1, sole clock; all logic on posedge.
REQ-007 SHALL have port rst_in, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have port a_in, input, signed 18, intercept from line fit (x10 scale).
REQ-009 SHALL have port b_in, input, signed 25, slope from line fit (x64 scale).
REQ-010 SHALL have port fit_valid_in, input, 1, a_in/b_in valid this cycle.
REQ-011 SHALL have port frame_tick_in, input, 1, one-cycle pulse per frame end.
REQ-012 SHALL have port x_query_in, input, unsigned 11, query column.
REQ-013 SHALL have port query_valid_in, input, 1, query request.
REQ-014 SHALL have ports a_smooth_out signed 18 and b_smooth_out signed 25, outputs, smoothed fit.
REQ-015 SHALL have port y_out, output, signed 20, predicted y at queried x.
REQ-016 SHALL have port y_valid_out, output, 1, y_out valid pulse.
REQ-017 SHALL have ports lock_out and stale_out, outputs, 1 each, state flags.

Function
REQ-018 SHALL implement states EMPTY, TRACKING, STALE; lock_out = (TRACKING), stale_out = (STALE).
REQ-019 EMPTY or STALE + fit_valid_in: SHALL load a_in/b_in directly (seed), clear counters, go TRACKING.
REQ-020 TRACKING + fit within both jump limits (inclusive): SHALL set smooth += (in - smooth) >>> ALPHA_SHIFT, 19/26-bit signed difference, arithmetic shift; reject counter cleared.
REQ-021 TRACKING + fit outside either limit: SHALL hold smooth values, increment reject counter; on reaching REJECT_LIMIT SHALL seed from that fit and clear counter.
REQ-022 Smoothed outputs SHALL update the cycle after the accepting fit_valid_in.
REQ-023 Per frame: fit-seen flag set by any fit_valid_in (accepted or rejected); frame_tick_in SHALL clear miss counter if flag set, else increment; flag cleared on tick.
REQ-024 fit_valid_in and frame_tick_in in same cycle: fit SHALL count for the ending frame.
REQ-025 TRACKING with miss counter reaching STALE_FRAMES: SHALL go STALE, holding last smooth values; miss counter saturates.
REQ-026 Query: 2-cycle pipeline; stage 1 registers signed product b_smooth * x_query (37 bits) using values present at request cycle; stage 2 y = a_smooth + (product >>> 6), saturated to signed 20.
REQ-027 y_valid_out SHALL pulse exactly 2 cycles after query_valid_in only if lock_out was high at request; else query dropped; one query per cycle, fully pipelined.
REQ-028 Fit update coincident with query: query SHALL use pre-update values.

Reset
REQ-029 rst_in SHALL asynchronously force EMPTY, all outputs 0, counters, flags and pipeline valids 0; in-flight queries discarded.

Structure
REQ-030 State enum and scale constants (A scale 10, B shift 6) SHALL live in the shared package.
REQ-031 Query pipeline SHALL be sub-module fit_eval (product, shift, add, saturate).

Verification
REQ-032 Reset, fit a=100,b=640 -> next cycle a_smooth=100, b_smooth=640, lock_out=1.
REQ-033 Then fit a=140,b=640 -> a_smooth=110, b_smooth=640.
REQ-034 Query x=5 in TRACKING (a=110,b=640) -> 2 cycles later y_out=160, y_valid_out=1 for one cycle.
REQ-035 Three consecutive fits a=500 from a=110 -> first two held at 110, third seeds a_smooth=500.
REQ-036 30 frame_ticks without fits -> stale_out=1, lock_out=0; query ignored; next fit a=20 seeds a_smooth=20.
REQ-037 rst_in mid-query -> y_valid_out never asserts, all outputs 0 immediately.

Source files
------------

// File: rtl/fit_smoother_pkg.sv
// Shared types and fixed-point constants for the line-fit smoother and its query evaluator.
package fit_smoother_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_TRACKING = 2'd1,
    ST_STALE    = 2'd2
  } state_t;

  // Intercept is carried in tenths of a pixel, slope in 1/64ths.
  localparam int A_SCALE = 10;
  localparam int B_SHIFT = 6;

  localparam int A_W    = 18;
  localparam int B_W    = 25;
  localparam int X_W    = 11;
  localparam int Y_W    = 20;
  localparam int PROD_W = B_W + X_W + 1;
  localparam int SUM_W  = PROD_W + 1;

  localparam logic signed [SUM_W-1:0] Y_MAX = SUM_W'((2 ** (Y_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] Y_MIN = SUM_W'(-(2 ** (Y_W - 1)));

  function automatic logic signed [Y_W-1:0] sat_y(input logic signed [SUM_W-1:0] v);
    if (v > Y_MAX) begin
      return Y_MAX[Y_W-1:0];
    end else if (v < Y_MIN) begin
      return Y_MIN[Y_W-1:0];
    end
    return v[Y_W-1:0];
  endfunction

endpackage

// File: rtl/fit_smoother_eval.sv
// Two-stage query evaluator: y = a + (b * x) >>> B_SHIFT, saturated to the y width.
module fit_eval
  import fit_smoother_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic signed [A_W-1:0] i_a,
  input  logic signed [B_W-1:0] i_b,
  input  logic        [X_W-1:0] i_x,
  output logic signed [Y_W-1:0] o_y,
  output logic                  o_y_valid
);

  logic                     r_v1;
  logic signed [PROD_W-1:0] r_prod;
  logic signed [A_W-1:0]    r_a1;
  logic signed [Y_W-1:0]    r_y;
  logic                     r_v2;

  logic signed [X_W:0]      w_x_s;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_shift;
  logic signed [SUM_W-1:0]  w_sum;

  // x is unsigned; a zero top bit keeps the product signed-correct.
  assign w_x_s   = $signed({1'b0, i_x});
  assign w_prod  = PROD_W'(i_b) * PROD_W'(w_x_s);
  assign w_shift = r_prod >>> B_SHIFT;
  assign w_sum   = SUM_W'(r_a1) + SUM_W'(w_shift);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v1   <= 1'b0;
      r_prod <= '0;
      r_a1   <= '0;
      r_v2   <= 1'b0;
      r_y    <= '0;
    end else begin
      r_v1 <= i_req;
      r_v2 <= r_v1;
      if (i_req) begin
        r_prod <= w_prod;
        r_a1   <= i_a;
      end
      if (r_v1) begin
        r_y <= sat_y(w_sum);
      end
    end
  end

  assign o_y       = r_y;
  assign o_y_valid = r_v2;

endmodule

// File: rtl/fit_smoother.sv
// Temporal smoother for per-frame line fits: EMA tracking with jump rejection, staleness, and y queries.
// Handshake: fit_valid_in/query_valid_in are single-cycle strobes with no back-pressure; y_valid_out pulses once per accepted query.
module fit_smoother
  import fit_smoother_pkg::*;
#(
  parameter int ALPHA_SHIFT  = 2,
  parameter int MAX_JUMP_A   = 64,
  parameter int MAX_JUMP_B   = 256,
  parameter int REJECT_LIMIT = 3,
  parameter int STALE_FRAMES = 30
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic signed [A_W-1:0] a_in,
  input  logic signed [B_W-1:0] b_in,
  input  logic                  fit_valid_in,
  input  logic                  frame_tick_in,
  input  logic        [X_W-1:0] x_query_in,
  input  logic                  query_valid_in,
  output logic signed [A_W-1:0] a_smooth_out,
  output logic signed [B_W-1:0] b_smooth_out,
  output logic signed [Y_W-1:0] y_out,
  output logic                  y_valid_out,
  output logic                  lock_out,
  output logic                  stale_out,
  output state_t                dbg_state_out
);

  localparam int REJ_W  = $clog2(REJECT_LIMIT + 1);
  localparam int MISS_W = $clog2(STALE_FRAMES + 1);
  localparam logic [REJ_W-1:0]  REJ_MAX  = REJ_W'(REJECT_LIMIT);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(STALE_FRAMES);
  localparam logic [A_W:0]      LIM_A    = (A_W + 1)'(MAX_JUMP_A);
  localparam logic [B_W:0]      LIM_B    = (B_W + 1)'(MAX_JUMP_B);

  state_t                r_state, w_state_nxt;
  logic signed [A_W-1:0] r_a, w_a_nxt;
  logic signed [B_W-1:0] r_b, w_b_nxt;
  logic [REJ_W-1:0]      r_rej, w_rej_nxt, w_rej_inc;
  logic [MISS_W-1:0]     r_miss, w_miss_nxt;
  logic                  r_fit_seen, w_fit_seen_nxt;
  logic                  w_seed;

  logic signed [A_W:0] w_diff_a, w_step_a, w_sum_a;
  logic signed [B_W:0] w_diff_b, w_step_b, w_sum_b;
  logic [A_W:0]        w_abs_a;
  logic [B_W:0]        w_abs_b;
  logic                w_accept;

  assign w_diff_a  = {a_in[A_W-1], a_in} - {r_a[A_W-1], r_a};
  assign w_diff_b  = {b_in[B_W-1], b_in} - {r_b[B_W-1], r_b};
  assign w_abs_a   = w_diff_a[A_W] ? -w_diff_a : w_diff_a;
  assign w_abs_b   = w_diff_b[B_W] ? -w_diff_b : w_diff_b;
  assign w_accept  = (w_abs_a <= LIM_A) && (w_abs_b <= LIM_B);
  assign w_step_a  = w_diff_a >>> ALPHA_SHIFT;
  assign w_step_b  = w_diff_b >>> ALPHA_SHIFT;
  assign w_sum_a   = {r_a[A_W-1], r_a} + w_step_a;
  assign w_sum_b   = {r_b[B_W-1], r_b} + w_step_b;
  assign w_rej_inc = r_rej + REJ_W'(1);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= ST_EMPTY;
      r_a        <= '0;
      r_b        <= '0;
      r_rej      <= '0;
      r_miss     <= '0;
      r_fit_seen <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_rej      <= w_rej_nxt;
      r_miss     <= w_miss_nxt;
      r_fit_seen <= w_fit_seen_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_rej_nxt      = r_rej;
    w_miss_nxt     = r_miss;
    w_fit_seen_nxt = r_fit_seen | fit_valid_in;
    w_seed         = 1'b0;

    // A fit arriving with the tick belongs to the frame that is ending.
    if (frame_tick_in) begin
      w_fit_seen_nxt = 1'b0;
      if (r_fit_seen || fit_valid_in) begin
        w_miss_nxt = '0;
      end else if (r_miss < MISS_MAX) begin
        w_miss_nxt = r_miss + MISS_W'(1);
      end
    end

    case (r_state)
      ST_EMPTY, ST_STALE: begin
        if (fit_valid_in) w_seed = 1'b1;
      end
      ST_TRACKING: begin
        if (fit_valid_in) begin
          if (w_accept) begin
            w_a_nxt   = w_sum_a[A_W-1:0];
            w_b_nxt   = w_sum_b[B_W-1:0];
            w_rej_nxt = '0;
          end else if (w_rej_inc >= REJ_MAX) begin
            w_seed = 1'b1;
          end else begin
            w_rej_nxt = w_rej_inc;
          end
        end else if (w_miss_nxt >= MISS_MAX) begin
          w_state_nxt = ST_STALE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase

    if (w_seed) begin
      w_a_nxt     = a_in;
      w_b_nxt     = b_in;
      w_rej_nxt   = '0;
      w_miss_nxt  = '0;
      w_state_nxt = ST_TRACKING;
    end
  end

  // Queries see the registered fit, so a coincident update is not visible to them.
  fit_eval u_eval (
    .i_clk     (clk_in),
    .i_rst     (rst_in),
    .i_req     (query_valid_in && (r_state == ST_TRACKING)),
    .i_a       (r_a),
    .i_b       (r_b),
    .i_x       (x_query_in),
    .o_y       (y_out),
    .o_y_valid (y_valid_out)
  );

  assign a_smooth_out  = r_a;
  assign b_smooth_out  = r_b;
  assign lock_out      = (r_state == ST_TRACKING);
  assign stale_out     = (r_state == ST_STALE);
  assign dbg_state_out = r_state;

endmodule

// File: tb/tb_fit_smoother.sv
// Directed bench for fit_smoother: state checks inline, query results through an expected queue.
module tb_fit_smoother;
  import fit_smoother_pkg::*;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b0;
  logic signed [17:0] a_in = '0;
  logic signed [24:0] b_in = '0;
  logic               fit_valid_in = 1'b0;
  logic               frame_tick_in = 1'b0;
  logic        [10:0] x_query_in = '0;
  logic               query_valid_in = 1'b0;
  logic signed [17:0] a_smooth_out;
  logic signed [24:0] b_smooth_out;
  logic signed [19:0] y_out;
  logic               y_valid_out;
  logic               lock_out;
  logic               stale_out;
  state_t             dbg_state_out;

  typedef struct packed {
    logic [31:0] due;
    logic [19:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  fit_smoother dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .a_in           (a_in),
    .b_in           (b_in),
    .fit_valid_in   (fit_valid_in),
    .frame_tick_in  (frame_tick_in),
    .x_query_in     (x_query_in),
    .query_valid_in (query_valid_in),
    .a_smooth_out   (a_smooth_out),
    .b_smooth_out   (b_smooth_out),
    .y_out          (y_out),
    .y_valid_out    (y_valid_out),
    .lock_out       (lock_out),
    .stale_out      (stale_out),
    .dbg_state_out  (dbg_state_out)
  );

  // Clock and cycle count
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_fit(input string name, input int a, input int b, input int lock, input int stale);
    check({name, " a_smooth"}, int'(a_smooth_out), a);
    check({name, " b_smooth"}, int'(b_smooth_out), b);
    check({name, " lock"}, int'(lock_out), lock);
    check({name, " stale"}, int'(stale_out), stale);
  endtask

  // One cycle of stimulus; entered and left #1 after a rising edge.
  task automatic step(input logic fv, input int a, input int b, input logic tk,
                      input logic qv, input int x, input logic qexp, input int y);
    exp_t e;
    fit_valid_in   = fv;
    a_in           = 18'(a);
    b_in           = 25'(b);
    frame_tick_in  = tk;
    query_valid_in = qv;
    x_query_in     = 11'(x);
    if (qv && qexp) begin
      e.due = 32'(cyc + 2);
      e.y   = 20'(y);
      exp_q.push_back(e);
    end
    @(posedge clk_in);
    #1;
    fit_valid_in   = 1'b0;
    frame_tick_in  = 1'b0;
    query_valid_in = 1'b0;
  endtask

  task automatic fit(input int a, input int b);
    step(1'b1, a, b, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic query(input int x, input logic qexp, input int y);
    step(1'b0, 0, 0, 1'b0, 1'b1, x, qexp, y);
  endtask

  task automatic tick();
    step(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk_in) begin
    if (y_valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_y: y_valid_out high with y=%0d, expected no output (cyc=%0d)", y_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("y_out", int'(y_out), int'($signed(e.y)));
        check("y_latency", cyc, int'(e.due));
      end
    end
  end

  initial begin
    #1 rst_in = 1'b1;
    #1;
    check_fit("reset", 0, 0, 0, 0);
    check("reset y_valid", int'(y_valid_out), 0);
    check("reset y", int'(y_out), 0);
    check("reset state", int'(dbg_state_out), int'(ST_EMPTY));
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;

    // Query while EMPTY is dropped
    query(5, 1'b0, 0);
    fit(100, 640);
    check_fit("seed", 100, 640, 1, 0);
    check("seed state", int'(dbg_state_out), int'(ST_TRACKING));
    fit(140, 640);
    check_fit("ema", 110, 640, 1, 0);

    // Inclusive jump limits, and query coincident with update sees old values
    step(1'b1, 174, 896, 1'b0, 1'b1, 5, 1'b1, 160);
    check_fit("limit accept", 126, 704, 1, 0);
    query(10, 1'b1, 236);
    query(0, 1'b1, 126);

    // Rejection: counter clears on an accepted fit
    fit(191, 704);
    check_fit("reject a+65", 126, 704, 1, 0);
    fit(126, 704);
    fit(126, 961);
    check_fit("reject b+257", 126, 704, 1, 0);
    fit(126, 704);
    fit(500, 704);
    check_fit("jump 1", 126, 704, 1, 0);
    fit(500, 704);
    check_fit("jump 2", 126, 704, 1, 0);
    fit(500, 704);
    check_fit("jump 3 reseed", 500, 704, 1, 0);
    query(2047, 1'b1, 23017);

    // Staleness: fit with tick counts for the ending frame
    step(1'b1, 500, 704, 1'b1, 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < 29; i++) tick();
    check_fit("29 misses", 500, 704, 1, 0);
    tick();
    check_fit("stale", 500, 704, 0, 1);
    check("stale state", int'(dbg_state_out), int'(ST_STALE));
    query(5, 1'b0, 0);
    fit(20, 100);
    check_fit("stale reseed", 20, 100, 1, 0);

    // Saturation of y in both directions
    for (int i = 0; i < 3; i++) fit(131071, 16777215);
    check_fit("max seed", 131071, 16777215, 1, 0);
    query(2047, 1'b1, 524287);
    for (int i = 0; i < 3; i++) fit(-131072, -16777216);
    check_fit("min seed", -131072, -16777216, 1, 0);
    query(2047, 1'b1, -524288);
    query(1, 1'b1, -393216);
    query(0, 1'b1, -131072);
    repeat (3) step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    check("queue drained", exp_q.size(), 0);

    // Reset with a query in flight
    query(5, 1'b1, -524288);
    #2;
    rst_in = 1'b1;
    exp_q.delete();
    #1;
    check_fit("async reset", 0, 0, 0, 0);
    check("async reset y", int'(y_out), 0);
    check("async reset y_valid", int'(y_valid_out), 0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    repeat (4) step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    check_fit("post reset", 0, 0, 0, 0);
    check("post reset queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
